// File: rtl/implication_queue.sv
// -----------------------------------------------------------------------------
// implication_queue
//
// Write side of the variable-assignment state read by the clause evaluators.
// It owns the per-variable assignment table (unassign/val vectors), accepts
// decisions and implications, detects conflicting implications, and buffers
// every newly assigned variable in a FIFO so the BCP controller can propagate
// the assignments one at a time.
//
// Optional build feature: define IMPLQ_STATS_EN to add three saturating 32-bit
// statistics outputs (stat_imp_accepted, stat_imp_dropped, stat_conflicts).
//
// Ports:
//   clock, reset_n                  rising-edge clock, async active-low reset
//   imp_valid/imp_var/imp_val       implication offer; imp_ready = accepted
//   dec_valid/dec_var/dec_val       decision offer;    dec_ready = accepted
//   undo_valid/undo_var             unassign a variable (backtrack)
//   flush                           empty FIFO, clear conflict, back to RUN
//   head_valid/head_var/head_val    oldest queued assignment (registered)
//   pop                             consume head (ignored when empty)
//   unassign, val                   assignment table, one bit per variable
//   conflict, conflict_var          sticky conflict flag and culprit variable
//   count                           FIFO occupancy
// -----------------------------------------------------------------------------
module implication_queue #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_BITS     = 7,
    parameter int QUEUE_DEPTH  = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            imp_valid,
    input  logic [VAR_BITS-1:0]             imp_var,
    input  logic                            imp_val,
    output logic                            imp_ready,
    input  logic                            dec_valid,
    input  logic [VAR_BITS-1:0]             dec_var,
    input  logic                            dec_val,
    output logic                            dec_ready,
    input  logic                            undo_valid,
    input  logic [VAR_BITS-1:0]             undo_var,
    input  logic                            flush,
    output logic                            head_valid,
    output logic [VAR_BITS-1:0]             head_var,
    output logic                            head_val,
    input  logic                            pop,
    output logic [NUM_VARIABLE-1:0]         unassign,
    output logic [NUM_VARIABLE-1:0]         val,
    output logic                            conflict,
    output logic [VAR_BITS-1:0]             conflict_var,
    output logic [$clog2(QUEUE_DEPTH):0]    count
`ifdef IMPLQ_STATS_EN
    ,
    output logic [31:0]                     stat_imp_accepted,
    output logic [31:0]                     stat_imp_dropped,
    output logic [31:0]                     stat_conflicts
`endif
);

    localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(QUEUE_DEPTH);
    localparam logic [CNT_BITS-1:0] ONE_C   = CNT_BITS'(1);
    localparam logic [VAR_BITS-1:0] NULL_C  = {VAR_BITS{1'b0}};

    typedef enum logic [0:0] {
        MODE_RUN      = 1'b0,
        MODE_CONFLICT = 1'b1
    } mode_t;

    // Registered state
    mode_t                      mode_r;
    logic [NUM_VARIABLE-1:0]    unassign_r;
    logic [NUM_VARIABLE-1:0]    val_r;
    logic                       conflict_r;
    logic [VAR_BITS-1:0]        conflict_var_r;
    logic [VAR_BITS:0]          mem_r [QUEUE_DEPTH];  // {var, val}
    logic [PTR_BITS-1:0]        rd_ptr_r;
    logic [PTR_BITS-1:0]        wr_ptr_r;
    logic [CNT_BITS-1:0]        count_r;
    logic                       head_valid_r;
    logic [VAR_BITS-1:0]        head_var_r;
    logic                       head_val_r;

    // Combinational decode
    logic                       dec_ready_s;
    logic                       imp_ready_s;
    logic                       dec_acc_s;
    logic                       imp_acc_s;
    logic                       dec_free_s;
    logic                       dec_write_s;
    logic                       imp_live_s;
    logic                       imp_write_s;
    logic                       imp_dup_s;
    logic                       imp_conf_s;
    logic                       push_s;
    logic [VAR_BITS-1:0]        push_var_s;
    logic                       push_val_s;
    logic                       pop_s;
    logic [PTR_BITS-1:0]        rd_next_s;
    logic [CNT_BITS-1:0]        count_next_s;
    logic [VAR_BITS-1:0]        head_var_next_s;
    logic                       head_val_next_s;

    assign dec_ready    = dec_ready_s;
    assign imp_ready    = imp_ready_s;
    assign unassign     = unassign_r;
    assign val          = val_r;
    assign conflict     = conflict_r;
    assign conflict_var = conflict_var_r;
    assign count        = count_r;
    assign head_valid   = head_valid_r;
    assign head_var     = head_var_r;
    assign head_val     = head_val_r;

    // Acceptance, table lookup and FIFO control decode
    always_comb begin
        dec_ready_s = (mode_r == MODE_RUN) & (count_r < DEPTH_C);
        // Decisions and undos own the cycle; implications wait behind them.
        imp_ready_s = dec_ready_s & ~dec_valid & ~undo_valid;

        // A flush discards any same-cycle decision or implication.
        dec_acc_s = dec_valid & dec_ready_s & ~flush;
        imp_acc_s = imp_valid & imp_ready_s & ~flush;

        // A same-cycle undo of the decision variable is applied first, so
        // the decision sees the variable free and ends up owning it.
        dec_free_s  = unassign_r[dec_var] |
                      (undo_valid & (undo_var == dec_var));
        dec_write_s = dec_acc_s & (dec_var != NULL_C) & dec_free_s;

        imp_live_s  = imp_acc_s & (imp_var != NULL_C);
        imp_write_s = imp_live_s & unassign_r[imp_var];
        imp_dup_s   = imp_live_s & ~unassign_r[imp_var] &
                      (val_r[imp_var] == imp_val);
        imp_conf_s  = imp_live_s & ~unassign_r[imp_var] &
                      (val_r[imp_var] != imp_val);

        // Decision and implication acceptance are mutually exclusive.
        push_s = dec_write_s | imp_write_s;
        if (dec_write_s) begin
            push_var_s = dec_var;
            push_val_s = dec_val;
        end else begin
            push_var_s = imp_var;
            push_val_s = imp_val;
        end

        pop_s     = pop & head_valid_r & ~flush;
        rd_next_s = rd_ptr_r + PTR_BITS'(1);

        if (flush) begin
            count_next_s = {CNT_BITS{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + ONE_C;
                2'b01:   count_next_s = count_r - ONE_C;
                default: count_next_s = count_r;
            endcase
        end

        // Next head: bypass the pushed entry when it becomes the oldest one,
        // otherwise read the slot the read pointer will point at.
        head_var_next_s = head_var_r;
        head_val_next_s = head_val_r;
        if (flush || (count_next_s == {CNT_BITS{1'b0}})) begin
            head_var_next_s = NULL_C;
            head_val_next_s = 1'b0;
        end else if (pop_s) begin
            if (count_r == ONE_C) begin
                head_var_next_s = push_var_s;
                head_val_next_s = push_val_s;
            end else begin
                head_var_next_s = mem_r[rd_next_s][VAR_BITS:1];
                head_val_next_s = mem_r[rd_next_s][0];
            end
        end else if (count_r == {CNT_BITS{1'b0}}) begin
            head_var_next_s = push_var_s;
            head_val_next_s = push_val_s;
        end else begin
            head_var_next_s = head_var_r;
            head_val_next_s = head_val_r;
        end
    end

    // Assignment table: undo first, then a decision or implication write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            unassign_r <= {NUM_VARIABLE{1'b1}};
            val_r      <= {NUM_VARIABLE{1'b0}};
        end else begin
            if (undo_valid) begin
                unassign_r[undo_var] <= 1'b1;
            end
            if (dec_write_s) begin
                unassign_r[dec_var] <= 1'b0;
                val_r[dec_var]      <= dec_val;
            end else if (imp_write_s) begin
                unassign_r[imp_var] <= 1'b0;
                val_r[imp_var]      <= imp_val;
            end
        end
    end

    // Mode FSM with the sticky conflict flag and culprit variable
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_r         <= MODE_RUN;
            conflict_r     <= 1'b0;
            conflict_var_r <= NULL_C;
        end else begin
            case (mode_r)
                MODE_RUN: begin
                    if (flush) begin
                        conflict_r     <= 1'b0;
                        conflict_var_r <= NULL_C;
                    end else if (imp_conf_s) begin
                        mode_r         <= MODE_CONFLICT;
                        conflict_r     <= 1'b1;
                        conflict_var_r <= imp_var;
                    end
                end
                MODE_CONFLICT: begin
                    if (flush) begin
                        mode_r         <= MODE_RUN;
                        conflict_r     <= 1'b0;
                        conflict_var_r <= NULL_C;
                    end
                end
                default: begin
                    mode_r         <= MODE_RUN;
                    conflict_r     <= 1'b0;
                    conflict_var_r <= NULL_C;
                end
            endcase
        end
    end

    // FIFO storage, pointers, occupancy and registered head
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_r[i] <= {(VAR_BITS+1){1'b0}};
            end
            rd_ptr_r     <= {PTR_BITS{1'b0}};
            wr_ptr_r     <= {PTR_BITS{1'b0}};
            count_r      <= {CNT_BITS{1'b0}};
            head_valid_r <= 1'b0;
            head_var_r   <= NULL_C;
            head_val_r   <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr_r <= {PTR_BITS{1'b0}};
                wr_ptr_r <= {PTR_BITS{1'b0}};
            end else begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= {push_var_s, push_val_s};
                    wr_ptr_r        <= wr_ptr_r + PTR_BITS'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_next_s;
                end
            end
            count_r      <= count_next_s;
            head_valid_r <= (count_next_s != {CNT_BITS{1'b0}});
            head_var_r   <= head_var_next_s;
            head_val_r   <= head_val_next_s;
        end
    end

`ifdef IMPLQ_STATS_EN
    logic [31:0] stat_acc_r;
    logic [31:0] stat_drop_r;
    logic [31:0] stat_conf_r;

    assign stat_imp_accepted = stat_acc_r;
    assign stat_imp_dropped  = stat_drop_r;
    assign stat_conflicts    = stat_conf_r;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_acc_r  <= 32'd0;
            stat_drop_r <= 32'd0;
            stat_conf_r <= 32'd0;
        end else begin
            if (imp_write_s && (stat_acc_r != 32'hFFFF_FFFF)) begin
                stat_acc_r <= stat_acc_r + 32'd1;
            end
            if (imp_dup_s && (stat_drop_r != 32'hFFFF_FFFF)) begin
                stat_drop_r <= stat_drop_r + 32'd1;
            end
            if (imp_conf_s && (mode_r == MODE_RUN) &&
                (stat_conf_r != 32'hFFFF_FFFF)) begin
                stat_conf_r <= stat_conf_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_implication_queue.sv
module tb_implication_queue;

    localparam int NV    = 128;
    localparam int VB    = 7;
    localparam int DEPTH = 8;
    localparam int CB    = $clog2(DEPTH) + 1;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            imp_valid, imp_val, dec_valid, dec_val, undo_valid, flush, pop;
    logic [VB-1:0]   imp_var, dec_var, undo_var;
    logic            imp_ready, dec_ready, head_valid, head_val, conflict;
    logic [VB-1:0]   head_var, conflict_var;
    logic [NV-1:0]   unassign, val;
    logic [CB-1:0]   count;
`ifdef IMPLQ_STATS_EN
    logic [31:0]     stat_imp_accepted, stat_imp_dropped, stat_conflicts;
`endif

    implication_queue #(.NUM_VARIABLE(NV), .VAR_BITS(VB), .QUEUE_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .imp_valid(imp_valid), .imp_var(imp_var), .imp_val(imp_val), .imp_ready(imp_ready),
        .dec_valid(dec_valid), .dec_var(dec_var), .dec_val(dec_val), .dec_ready(dec_ready),
        .undo_valid(undo_valid), .undo_var(undo_var), .flush(flush),
        .head_valid(head_valid), .head_var(head_var), .head_val(head_val), .pop(pop),
        .unassign(unassign), .val(val), .conflict(conflict), .conflict_var(conflict_var),
        .count(count)
`ifdef IMPLQ_STATS_EN
        , .stat_imp_accepted(stat_imp_accepted), .stat_imp_dropped(stat_imp_dropped),
        .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model: plain arrays and a queue of {var,val}
    bit [NV-1:0]  m_un;
    bit [NV-1:0]  m_val;
    bit [VB:0]    m_q[$];
    bit           m_conf;
    bit [VB-1:0]  m_cvar;
    int           m_acc, m_drop, m_nconf;

    task automatic lit(input string name, input logic [NV-1:0] act, input logic [NV-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_un = '1; m_val = '0; m_q.delete(); m_conf = 1'b0; m_cvar = '0;
        m_acc = 0; m_drop = 0; m_nconf = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs present at the edge
    task automatic model_step();
        bit dec_rdy, imp_rdy;
        dec_rdy = !m_conf && (m_q.size() < DEPTH);
        imp_rdy = dec_rdy && !dec_valid && !undo_valid;
        if (undo_valid) m_un[undo_var] = 1'b1;
        if (flush) begin
            m_q.delete(); m_conf = 1'b0; m_cvar = '0;
        end else begin
            if (pop && m_q.size() > 0) void'(m_q.pop_front());
            if (dec_valid && dec_rdy) begin
                if (dec_var != 0 && m_un[dec_var]) begin
                    m_un[dec_var] = 1'b0; m_val[dec_var] = dec_val;
                    m_q.push_back({dec_var, dec_val});
                end
            end else if (imp_valid && imp_rdy && imp_var != 0) begin
                if (m_un[imp_var]) begin
                    m_un[imp_var] = 1'b0; m_val[imp_var] = imp_val;
                    m_q.push_back({imp_var, imp_val}); m_acc++;
                end else if (m_val[imp_var] == imp_val) begin
                    m_drop++;
                end else begin
                    m_conf = 1'b1; m_cvar = imp_var; m_nconf++;
                end
            end
        end
    endtask

    task automatic idle();
        imp_valid = 0; imp_var = '0; imp_val = 0;
        dec_valid = 0; dec_var = '0; dec_val = 0;
        undo_valid = 0; undo_var = '0; flush = 0; pop = 0;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1 idle();
    endtask

    // Per-cycle comparison of every meaningful output against the model
    always @(negedge clock) begin
        if (chk_en) begin
            bit exp_dec_rdy;
            exp_dec_rdy = !m_conf && (m_q.size() < DEPTH);
            lit("count", NV'(count), NV'(m_q.size()));
            lit("head_valid", NV'(head_valid), NV'(m_q.size() > 0));
            if (m_q.size() > 0) lit("head", NV'({head_var, head_val}), NV'(m_q[0]));
            lit("conflict", NV'(conflict), NV'(m_conf));
            lit("conflict_var", NV'(conflict_var), NV'(m_cvar));
            lit("unassign", unassign, m_un);
            lit("val", val & ~unassign, m_val & ~m_un);
            lit("dec_ready", NV'(dec_ready), NV'(exp_dec_rdy));
            lit("imp_ready", NV'(imp_ready), NV'(exp_dec_rdy && !dec_valid && !undo_valid));
`ifdef IMPLQ_STATS_EN
            lit("stat_acc", NV'(stat_imp_accepted), NV'(m_acc));
            lit("stat_drop", NV'(stat_imp_dropped), NV'(m_drop));
            lit("stat_conf", NV'(stat_conflicts), NV'(m_nconf));
`endif
        end
    end

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clock); #1;

        // Reset state
        lit("rst_count", NV'(count), NV'(0));
        lit("rst_head_valid", NV'(head_valid), NV'(0));
        lit("rst_head_var", NV'(head_var), NV'(0));
        lit("rst_conflict", NV'(conflict), NV'(0));
        lit("rst_unassign", unassign, {NV{1'b1}});
        lit("rst_val", val, {NV{1'b0}});

        // Decision var 5 = 1
        dec_valid = 1; dec_var = 7'd5; dec_val = 1; step();
        lit("dec5_unassign", NV'(unassign[5]), NV'(0));
        lit("dec5_val", NV'(val[5]), NV'(1));
        lit("dec5_head", NV'({head_valid, head_var, head_val}), NV'({1'b1, 7'd5, 1'b1}));
        lit("dec5_count", NV'(count), NV'(1));

        // Implication 9 = 0, then duplicate
        imp_valid = 1; imp_var = 7'd9; imp_val = 0; step();
        lit("imp9_count", NV'(count), NV'(2));
        imp_valid = 1; imp_var = 7'd9; imp_val = 0; step();
        lit("imp9dup_count", NV'(count), NV'(2));
`ifdef IMPLQ_STATS_EN
        lit("imp9dup_stat", NV'(stat_imp_dropped), NV'(1));
`endif

        // Conflicting implication, then flush
        imp_valid = 1; imp_var = 7'd9; imp_val = 1; step();
        lit("conf_flag", NV'(conflict), NV'(1));
        lit("conf_var", NV'(conflict_var), NV'(9));
        lit("conf_imp_ready", NV'(imp_ready), NV'(0));
        lit("conf_dec_ready", NV'(dec_ready), NV'(0));
        flush = 1; step();
        lit("flush_conflict", NV'(conflict), NV'(0));
        lit("flush_count", NV'(count), NV'(0));
        lit("flush_table", NV'(unassign[9]), NV'(0));

        undo_valid = 1; undo_var = 7'd5; step();
        undo_valid = 1; undo_var = 7'd9; step();

        // Fill the FIFO with vars 1..8
        for (int i = 1; i <= 8; i++) begin
            imp_valid = 1; imp_var = VB'(i); imp_val = i[0]; step();
        end
        lit("full_count", NV'(count), NV'(8));
        lit("full_imp_ready", NV'(imp_ready), NV'(0));
        imp_valid = 1; imp_var = 7'd10; imp_val = 1; #1;
        lit("stall_imp_ready", NV'(imp_ready), NV'(0));
        step();
        lit("stall_count", NV'(count), NV'(8));
        lit("stall_table", NV'(unassign[10]), NV'(1));
        for (int i = 1; i <= 8; i++) begin
            lit("drain_head", NV'(head_var), NV'(i));
            pop = 1; step();
        end
        lit("drain_empty", NV'(head_valid), NV'(0));

        // Decision beats implication; undo+decision on same variable
        undo_valid = 1; undo_var = 7'd3; step();
        undo_valid = 1; undo_var = 7'd4; step();
        dec_valid = 1; dec_var = 7'd3; dec_val = 1;
        imp_valid = 1; imp_var = 7'd4; imp_val = 0; #1;
        lit("prio_imp_ready", NV'(imp_ready), NV'(0));
        lit("prio_dec_ready", NV'(dec_ready), NV'(1));
        step();
        lit("prio_var3", NV'(unassign[3]), NV'(0));
        lit("prio_var4", NV'(unassign[4]), NV'(1));
        imp_valid = 1; imp_var = 7'd4; imp_val = 0; step();
        lit("later_var4", NV'(unassign[4]), NV'(0));
        undo_valid = 1; undo_var = 7'd3; dec_valid = 1; dec_var = 7'd3; dec_val = 0; step();
        lit("undo_dec_var3", NV'({unassign[3], val[3]}), NV'(2'b00));
        lit("undo_dec_count", NV'(count), NV'(3));

        // Null implication
        imp_valid = 1; imp_var = 7'd0; imp_val = 1; step();
        lit("null_count", NV'(count), NV'(3));
        lit("null_table", NV'(unassign[0]), NV'(1));

        // Reset mid-stream with count 5
        imp_valid = 1; imp_var = 7'd11; imp_val = 1; step();
        imp_valid = 1; imp_var = 7'd12; imp_val = 1; step();
        lit("pre_rst_count", NV'(count), NV'(5));
        #2 reset_n = 1'b0; model_reset();
        #1;
        lit("mid_rst_count", NV'(count), NV'(0));
        lit("mid_rst_unassign", unassign, {NV{1'b1}});
        @(posedge clock); #3 reset_n = 1'b1;
        @(posedge clock); #1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit [6:0] r;
            r = 7'($urandom_range(0, 99));
            if (r < (m_conf ? 7'd20 : 7'd2)) begin
                flush = 1;
                undo_valid = ($urandom_range(0, 3) == 0);
                undo_var = VB'($urandom_range(0, 15));
                pop = $urandom_range(0, 1) == 1;
            end else begin
                dec_valid  = ($urandom_range(0, 4) == 0);
                dec_var    = VB'($urandom_range(0, 15));
                dec_val    = 1'($urandom_range(0, 1));
                imp_valid  = ($urandom_range(0, 1) == 1);
                imp_var    = VB'($urandom_range(0, 15));
                imp_val    = 1'($urandom_range(0, 1));
                undo_valid = ($urandom_range(0, 6) == 0);
                undo_var   = (($urandom_range(0, 1) == 1) ? dec_var : VB'($urandom_range(0, 15)));
                pop        = ($urandom_range(0, 9) < 4);
            end
            step();
        end

        @(posedge clock); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
